// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-approach signal controller with run-time timings, all-red clearance,
// demand-actuated skipping, rest-on-green and emergency preemption.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR = 4,
  parameter int CNT_W   = 8,
  parameter int SKIP_EN = 1,
  localparam int DIR_W  = $clog2(NUM_DIR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       green_time,
  input  logic [CNT_W-1:0]       yellow_time,
  input  logic [CNT_W-1:0]       allred_time,
  input  logic [NUM_DIR-1:0]     demand,
  input  logic                   preempt_req,
  input  logic [DIR_W-1:0]       preempt_dir,
  output logic [2*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase,
  output logic                   preempt_active
);
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] ALLRED = 2'b10;

  logic [1:0]       phase_q, phase_d;
  logic [DIR_W-1:0] active_q, active_d, next_q, next_d, cand, rr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pa_q, pa_d, found, pv;

  // a timing value of 0 behaves as a one-cycle phase
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [DIR_W-1:0] wrap(input logic [DIR_W-1:0] a, input int i);
    return DIR_W'((int'(a) + i) % NUM_DIR);
  endfunction

  assign pv = preempt_req && (int'(preempt_dir) < NUM_DIR);
  assign rr = wrap(active_q, 1);

  // descending scan so the nearest demanding approach after active_dir wins
  always_comb begin
    cand  = '0;
    found = 1'b0;
    for (int i = NUM_DIR - 1; i >= 1; i--) begin
      if (demand[wrap(active_q, i)]) begin
        found = 1'b1;
        cand  = wrap(active_q, i);
      end
    end
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    pa_d     = pa_q;
    case (phase_q)
      GREEN: begin
        if (pv && preempt_dir == active_q) pa_d = 1'b1;
        else if (pv) begin
          phase_d = YELLOW;
          cnt_d   = ld(yellow_time);
          next_d  = preempt_dir;
          pa_d    = 1'b1;
        end else if (pa_q) begin
          cnt_d = ld(green_time);
          pa_d  = 1'b0;
        end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (SKIP_EN == 0 || found) begin
          phase_d = YELLOW;
          cnt_d   = ld(yellow_time);
          next_d  = (SKIP_EN != 0) ? cand : rr;
        end else cnt_d = ld(green_time);
      end
      YELLOW: begin
        if (pv) begin
          next_d = preempt_dir;
          pa_d   = 1'b1;
        end
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          phase_d = ALLRED;
          cnt_d   = ld(allred_time);
        end
      end
      ALLRED: begin
        if (pv) begin
          next_d = preempt_dir;
          pa_d   = 1'b1;
        end
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          phase_d  = GREEN;
          active_d = pv ? preempt_dir : next_q;
          cnt_d    = ld(green_time);
        end
      end
      default: begin
        phase_d = GREEN;
        cnt_d   = ld(green_time);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= GREEN;
      active_q <= '0;
      next_q   <= DIR_W'(1);
      cnt_q    <= ld(green_time);
      pa_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      pa_q     <= pa_d;
    end
  end

  always_comb begin
    lights = '0;
    if (phase_q != ALLRED) lights[{active_q, 1'b0} +: 2] = (phase_q == GREEN) ? 2'b10 : 2'b01;
  end

  assign active_dir     = active_q;
  assign phase          = phase_q;
  assign preempt_active = pa_q;
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: directed scenarios; per-cycle expected phase/direction/preempt
// entries are queued ahead of time and popped against the DUT each cycle.
module tb_traffic_light_ctrl_n;
  localparam int N = 4;
  localparam logic [1:0] G = 2'b00, Y = 2'b01, A = 2'b10;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] dir;
    logic       pa;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [7:0]   green_time = 8'd5, yellow_time = 8'd2, allred_time = 8'd1;
  logic [N-1:0] demand = '1;
  logic         preempt_req = 1'b0;
  logic [1:0]   preempt_dir = '0;
  logic [2*N-1:0] lights;
  logic [1:0]   active_dir, phase;
  logic         preempt_active;

  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  traffic_light_ctrl_n #(.NUM_DIR(N), .CNT_W(8), .SKIP_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .green_time(green_time), .yellow_time(yellow_time),
    .allred_time(allred_time), .demand(demand), .preempt_req(preempt_req),
    .preempt_dir(preempt_dir), .lights(lights), .active_dir(active_dir),
    .phase(phase), .preempt_active(preempt_active)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] lamp(input exp_t e);
    logic [2*N-1:0] l;
    for (int d = 0; d < N; d++)
      l[2*d +: 2] = (d != int'(e.dir) || e.ph == A) ? 2'b00 : (e.ph == G ? 2'b10 : 2'b01);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(input logic [1:0] ph, input logic [1:0] dir, input logic pa, input int n);
    exp_t e;
    e.ph = ph; e.dir = dir; e.pa = pa;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic push_rot(input logic [1:0] dir, input int g, input int y, input int a);
    push(G, dir, 1'b0, g);
    push(Y, dir, 1'b0, y);
    push(A, dir, 1'b0, a);
  endtask

  task automatic cmp(input string t);
    exp_t e;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s c%0d scoreboard empty", t, cyc);
      return;
    end
    e = q.pop_front();
    chk($sformatf("%s c%0d phase", t, cyc), 32'(phase), 32'(e.ph));
    chk($sformatf("%s c%0d dir", t, cyc), 32'(active_dir), 32'(e.dir));
    chk($sformatf("%s c%0d preempt", t, cyc), 32'(preempt_active), 32'(e.pa));
    chk($sformatf("%s c%0d lights", t, cyc), 32'(lights), 32'(lamp(e)));
  endtask

  task automatic run(input string t, input int n);
    for (int i = 0; i < n; i++) begin
      cmp(t);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // full rotation with every approach demanding
    reset_dut();
    for (int d = 0; d < N; d++) push_rot(2'(d), 5, 2, 1);
    push(G, 2'd0, 1'b0, 1);
    run("rot", 33);

    // approaches 1 and 2 are skipped
    demand = 4'b1001;
    reset_dut();
    push_rot(2'd0, 5, 2, 1);
    push_rot(2'd3, 5, 2, 1);
    push(G, 2'd0, 1'b0, 1);
    run("skip", 17);

    // rest on green, then late demand on approach 2
    demand = '0;
    reset_dut();
    push(G, 2'd0, 1'b0, 100);
    run("rest", 100);
    demand = 4'b0100;
    push_rot(2'd0, 5, 2, 1);
    push(G, 2'd2, 1'b0, 1);
    run("wake", 9);

    // preemption to approach 2 truncating approach 0 green
    demand = '1;
    reset_dut();
    push(G, 2'd0, 1'b0, 2);
    run("pre", 2);
    preempt_req = 1'b1;
    preempt_dir = 2'd2;
    push(G, 2'd0, 1'b0, 1);
    push(Y, 2'd0, 1'b1, 2);
    push(A, 2'd0, 1'b1, 1);
    push(G, 2'd2, 1'b1, 50);
    run("pre", 54);
    preempt_req = 1'b0;
    push(G, 2'd2, 1'b1, 1);
    push(G, 2'd2, 1'b0, 5);
    push(Y, 2'd2, 1'b0, 2);
    push(A, 2'd2, 1'b0, 1);
    push(G, 2'd3, 1'b0, 1);
    run("release", 10);

    // zero timings act as one-cycle phases
    green_time = '0; yellow_time = '0; allred_time = '0;
    reset_dut();
    for (int d = 0; d < N; d++) push_rot(2'(d), 1, 1, 1);
    push(G, 2'd0, 1'b0, 1);
    run("zero", 13);

    // asynchronous reset mid-yellow of approach 1
    green_time = 8'd5; yellow_time = 8'd2; allred_time = 8'd1;
    reset_dut();
    push_rot(2'd0, 5, 2, 1);
    push(G, 2'd1, 1'b0, 5);
    push(Y, 2'd1, 1'b0, 1);
    run("pre_rst", 14);
    push(Y, 2'd1, 1'b0, 1);
    cmp("midyel");
    #1 rst_n = 1'b0;
    #1 push(G, 2'd0, 1'b0, 1);
    cmp("async_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
- Parametrised N-approach intersection controller. Successor to the fixed 4-way, fixed-timing controller.
- Adds run-time phase timings, an all-red clearance phase, and demand-actuated skipping of empty approaches.
- Adds rest-on-green when no other approach has demand, and emergency-vehicle preemption.
- Drives one 2-bit lamp code per approach (2'b10 green, 2'b01 yellow, 2'b00 red) for the signal-head driver block.

Parameters:
- NUM_DIR, 4, number of approaches (>=2).
- CNT_W, 8, width of timing inputs and phase counter.
- SKIP_EN, 1, 1 = demand-actuated skipping and rest-on-green; 0 = fixed round-robin, demand ignored.
- DIR_W, $clog2(NUM_DIR), localparam, width of direction indices.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- green_time  in  CNT_W  green duration in cycles.
- yellow_time  in  CNT_W  yellow duration in cycles.
- allred_time  in  CNT_W  all-red clearance duration in cycles.
- demand  in  NUM_DIR  per-approach vehicle/pedestrian demand, level.
- preempt_req  in  1  emergency preemption request, level.
- preempt_dir  in  DIR_W  approach to serve during preemption.
- lights  out  2*NUM_DIR  lamp code; approach d occupies bits [2d+1:2d].
- active_dir  out  DIR_W  approach currently owning green/yellow.
- phase  out  2  2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALLRED.
- preempt_active  out  1  high while a preemption is being served.

Behaviour:
- Reset is asynchronous and applies immediately from any state, including mid-yellow or mid-preempt. Reset values:
  - phase = GREEN, active_dir = 0, preempt_active = 0.
  - lights: approach 0 = 2'b10, all others 2'b00.
  - counter = max(green_time,1)-1; next_dir = 1.
- Phase timing:
  - On phase entry, counter loads max(T,1)-1, where T is the timing input for that phase, sampled at that edge. Later changes to T do not affect the running phase.
  - Each edge with counter != 0 decrements the counter. The edge with counter == 0 ends the phase.
  - A phase therefore lasts exactly max(T,1) cycles; T = 0 behaves as 1.
- Lamp decode is combinational from phase and active_dir:
  - GREEN: lights[active_dir] = 10.
  - YELLOW: lights[active_dir] = 01.
  - ALLRED: every approach = 00.
  - Every approach other than active_dir is always 00. At most one approach is ever non-red.
- GREEN end (counter == 0, no preemption):
  - Candidate = first d searched from active_dir+1 upward, wrapping modulo NUM_DIR, excluding active_dir, with demand[d] = 1.
  - Candidate found: next_dir <= candidate; go to YELLOW.
  - No candidate and SKIP_EN=1 (rest-on-green): stay in GREEN and reload the counter with green_time. Newly arriving demand is serviced at the next expiry.
  - SKIP_EN=0: next_dir <= (active_dir+1) mod NUM_DIR; go to YELLOW. The demand input is ignored entirely.
- YELLOW end -> ALLRED. ALLRED end -> GREEN with active_dir <= next_dir.
- Preemption (preempt_req=1 and preempt_dir < NUM_DIR; otherwise the request is ignored):
  - In GREEN with active_dir != preempt_dir: at the next edge go to YELLOW, truncating the green; next_dir <= preempt_dir; preempt_active <= 1.
  - In YELLOW or ALLRED: the phase runs to completion; next_dir <= preempt_dir; preempt_active <= 1.
  - In GREEN with active_dir == preempt_dir: preempt_active = 1; the counter is held and the phase never expires.
  - When preempt_req deasserts while holding: the counter reloads green_time; preempt_active <= 0; normal operation resumes.
  - A change of preempt_dir mid-preemption retargets next_dir, unless the machine is already holding green. Holding green with a changed preempt_dir counts as a new request from GREEN.
  - Preemption overrides SKIP_EN and rest-on-green.
- Demand is sampled only at GREEN expiry. Demand pulses that do not overlap an expiry edge are not latched.

Test Plan:
- NUM_DIR=4, green=5, yellow=2, allred=1, demand=4'b1111, release reset -> approach 0 green for 5 cycles, yellow 2, all-red 1; approach 1 green at cycle 8. Full rotation takes 32 cycles and active_dir returns to 0 at cycle 32.
- demand=4'b1001 -> after approach 0's all-red, approach 3 goes green; approaches 1 and 2 never leave 00.
- demand=0, SKIP_EN=1 -> approach 0 green for 100 cycles, phase never leaves GREEN. Then raise demand[2] -> approach 2 green within green+yellow+allred+... ≤ 5+2+1+1 cycles of the next expiry.
- preempt_req=1, preempt_dir=2 at cycle 2 of approach 0 green -> yellow at cycle 3, all-red, then approach 2 green with preempt_active=1, held 50 cycles. Deassert -> green lasts exactly 5 more cycles, preempt_active=0.
- green=0, yellow=0, allred=0 -> each phase lasts 1 cycle; rotation period 12 cycles.
- Assert rst_n=0 mid-yellow of approach 1 -> same cycle lights = approach 0 green, others red, phase=00, preempt_active=0.
